// File: rtl/pc11_fifo.sv
// PC11 paper tape reader/punch Unibus slave with byte FIFOs between the ARM tape emulator and the PDP registers.
// Optional feature macro PC11F_OVFERR_EN: FIFO overflows set the matching ERROR bit (rcsr[15] / xcsr[15]).
module pc11_fifo #(
    parameter logic [17:0] ADDR     = 18'o777550,
    parameter logic [7:0]  INTVEC   = 8'o070,
    parameter int          RDEPTHL2 = 4,
    parameter int          PDEPTHL2 = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        intreq,
    output logic [7:0]  intvec,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        init_in_h,
    input  logic        msyn_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h
);

`ifdef PC11F_OVFERR_EN
    localparam bit OVF_ERR = 1'b1;
`else
    localparam bit OVF_ERR = 1'b0;
`endif

    localparam int RDEPTH = 1 << RDEPTHL2;
    localparam int PDEPTH = 1 << PDEPTHL2;
    localparam int RCW    = RDEPTHL2 + 1;
    localparam int PCW    = PDEPTHL2 + 1;

    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;

    rd_state_t rd_state_q, rd_state_d;
    logic        enable_q, enable_d;
    logic [15:0] rcsr_q, rcsr_d;
    logic [15:0] xcsr_q, xcsr_d;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [7:0]  xbuf_q, xbuf_d;
    logic [15:0] d_out_q, d_out_d;
    logic        ssyn_q, ssyn_d;

    logic [7:0]          rmem [RDEPTH];
    logic [7:0]          pmem [PDEPTH];
    logic [RDEPTHL2-1:0] rwr_ptr_q, rwr_ptr_d, rrd_ptr_q, rrd_ptr_d;
    logic [PDEPTHL2-1:0] pwr_ptr_q, pwr_ptr_d, prd_ptr_q, prd_ptr_d;
    logic [RCW-1:0]      rcnt_q, rcnt_d;
    logic [PCW-1:0]      pcnt_q, pcnt_d;

    logic        rpush, rpop, rflush, ppush, ppop, pflush;
    logic        rfull, rempty, pfull, pempty;
    logic [7:0]  rhead, phead;
    logic [15:0] xcsr_live;
    logic        rirq, xirq, arm_abort;

    assign rfull  = (rcnt_q == RCW'(RDEPTH));
    assign rempty = (rcnt_q == '0);
    assign pfull  = (pcnt_q == PCW'(PDEPTH));
    assign pempty = (pcnt_q == '0);
    // Empty FIFOs present a zero head so stale RAM contents never leak out.
    assign rhead  = rempty ? 8'd0 : rmem[rrd_ptr_q];
    assign phead  = pempty ? 8'd0 : pmem[prd_ptr_q];

    // Punch READY is not stored; it always reflects the FIFO having room.
    assign xcsr_live = {xcsr_q[15:8], ~pfull, xcsr_q[6:0]};

    assign rirq   = (rcsr_q[15] | rcsr_q[7]) & rcsr_q[6];
    assign xirq   = (xcsr_live[15] | xcsr_live[7]) & xcsr_live[6];
    assign intreq = rirq | xirq;
    assign intvec = {INTVEC[7:3], ~rirq, 2'b00};

    assign d_out_h    = d_out_q;
    assign ssyn_out_h = ssyn_q;

    always_comb begin
        armrdata = 32'h50431002;
        case (armraddr)
            2'd1:    armrdata = {rbuf_q, 8'(rcnt_q), rcsr_q};
            2'd2:    armrdata = {phead, 8'(pcnt_q), xcsr_live};
            2'd3:    armrdata = {enable_q, 5'b0, INTVEC, ADDR};
            default: armrdata = 32'h50431002;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        enable_d   = enable_q;
        rcsr_d     = rcsr_q;
        xcsr_d     = xcsr_q;
        rbuf_d     = rbuf_q;
        xbuf_d     = xbuf_q;
        d_out_d    = d_out_q;
        ssyn_d     = ssyn_q;
        rpush      = 1'b0;
        rpop       = 1'b0;
        rflush     = 1'b0;
        ppush      = 1'b0;
        ppop       = 1'b0;
        pflush     = 1'b0;
        arm_abort  = 1'b0;

        // An ARM write owns the cycle; a pending Unibus cycle is serviced on the next clock.
        if (armwrite) begin
            case (armwaddr)
                2'd1: begin
                    rcsr_d[15] = armwdata[15];
                    if (armwdata[25]) begin
                        rflush = 1'b1;
                    end else if (armwdata[24]) begin
                        if (!rfull) begin
                            rpush = 1'b1;
                        end else if (OVF_ERR) begin
                            rcsr_d[15] = 1'b1;
                        end
                    end
                    if (armwdata[15] && rd_state_q == RD_WAIT) begin
                        arm_abort  = 1'b1;
                        rd_state_d = RD_IDLE;
                        rcsr_d[11] = 1'b0;
                    end
                end
                2'd2: begin
                    xcsr_d[15] = armwdata[15];
                    if (armwdata[25]) begin
                        pflush = 1'b1;
                    end else if (armwdata[24] && !pempty) begin
                        ppop = 1'b1;
                    end
                end
                2'd3: enable_d = armwdata[31];
                default: ;
            endcase
        end else if (!init_in_h) begin
            if (!msyn_in_h) begin
                d_out_d = '0;
                ssyn_d  = 1'b0;
            end else if (enable_q && a_in_h[17:3] == ADDR[17:3] && !ssyn_q) begin
                ssyn_d = 1'b1;
                if (!c_in_h[1]) begin
                    case (a_in_h[2:1])
                        2'd0: d_out_d = rcsr_q & 16'o104300;
                        2'd1: begin
                            d_out_d   = {8'd0, rbuf_q};
                            rcsr_d[7] = 1'b0;
                        end
                        2'd2:    d_out_d = xcsr_live & 16'o100300;
                        default: d_out_d = {8'd0, xbuf_q};
                    endcase
                end else if (a_in_h[2:1] == 2'd3) begin
                    // XBUF pushes even on an odd-byte write.
                    if (!pfull) begin
                        ppush  = 1'b1;
                        xbuf_d = d_in_h[7:0];
                    end else if (OVF_ERR) begin
                        xcsr_d[15] = 1'b1;
                    end
                end else if (!(c_in_h[0] && a_in_h[0])) begin
                    case (a_in_h[2:1])
                        2'd0: begin
                            rcsr_d[6] = d_in_h[6];
                            if (d_in_h[0] && rd_state_q == RD_IDLE) begin
                                rcsr_d[7]  = 1'b0;
                                rcsr_d[11] = 1'b1;
                                rbuf_d     = 8'd0;
                                rd_state_d = RD_WAIT;
                            end
                        end
                        2'd2:    xcsr_d[6] = d_in_h[6];
                        default: ;
                    endcase
                end
            end
        end

        if (rd_state_q == RD_WAIT && !rempty && !arm_abort && !rflush && !init_in_h) begin
            rbuf_d     = rhead;
            rpop       = 1'b1;
            rcsr_d[11] = 1'b0;
            rcsr_d[7]  = 1'b1;
            rd_state_d = RD_IDLE;
        end

        if (init_in_h) begin
            rcsr_d     = '0;
            xcsr_d[15] = 1'b0;
            xcsr_d[6]  = 1'b0;
            d_out_d    = '0;
            ssyn_d     = 1'b0;
            rd_state_d = RD_IDLE;
        end
    end

    always_comb begin
        rwr_ptr_d = rwr_ptr_q;
        rrd_ptr_d = rrd_ptr_q;
        rcnt_d    = rcnt_q;
        pwr_ptr_d = pwr_ptr_q;
        prd_ptr_d = prd_ptr_q;
        pcnt_d    = pcnt_q;
        if (rflush) begin
            rwr_ptr_d = '0;
            rrd_ptr_d = '0;
            rcnt_d    = '0;
        end else begin
            if (rpush) rwr_ptr_d = rwr_ptr_q + RDEPTHL2'(1);
            if (rpop)  rrd_ptr_d = rrd_ptr_q + RDEPTHL2'(1);
            rcnt_d = rcnt_q + RCW'(rpush) - RCW'(rpop);
        end
        if (pflush) begin
            pwr_ptr_d = '0;
            prd_ptr_d = '0;
            pcnt_d    = '0;
        end else begin
            if (ppush) pwr_ptr_d = pwr_ptr_q + PDEPTHL2'(1);
            if (ppop)  prd_ptr_d = prd_ptr_q + PDEPTHL2'(1);
            pcnt_d = pcnt_q + PCW'(ppush) - PCW'(ppop);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rpush) rmem[rwr_ptr_q] <= armwdata[23:16];
        if (ppush) pmem[pwr_ptr_q] <= d_in_h[7:0];
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            rd_state_q <= RD_IDLE;
            enable_q   <= 1'b0;
            rcsr_q     <= '0;
            xcsr_q     <= '0;
            rbuf_q     <= '0;
            xbuf_q     <= '0;
            d_out_q    <= '0;
            ssyn_q     <= 1'b0;
            rwr_ptr_q  <= '0;
            rrd_ptr_q  <= '0;
            rcnt_q     <= '0;
            pwr_ptr_q  <= '0;
            prd_ptr_q  <= '0;
            pcnt_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            enable_q   <= enable_d;
            rcsr_q     <= rcsr_d;
            xcsr_q     <= xcsr_d;
            rbuf_q     <= rbuf_d;
            xbuf_q     <= xbuf_d;
            d_out_q    <= d_out_d;
            ssyn_q     <= ssyn_d;
            rwr_ptr_q  <= rwr_ptr_d;
            rrd_ptr_q  <= rrd_ptr_d;
            rcnt_q     <= rcnt_d;
            pwr_ptr_q  <= pwr_ptr_d;
            prd_ptr_q  <= prd_ptr_d;
            pcnt_q     <= pcnt_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{armwdata[30:26], armwdata[14:0], d_in_h[15:8], xcsr_q[7]};

endmodule

// File: tb/tb_pc11_fifo.sv
// Directed bench for pc11_fifo: ARM register window, reader FSM, punch FIFO, bus priority and INIT.
module tb_pc11_fifo;

    logic        CLOCK, RESET;
    logic        armwrite;
    logic [1:0]  armraddr, armwaddr;
    logic [31:0] armwdata, armrdata;
    logic        intreq;
    logic [7:0]  intvec;
    logic [17:0] a_in_h;
    logic [1:0]  c_in_h;
    logic [15:0] d_in_h;
    logic        init_in_h, msyn_in_h;
    logic [15:0] d_out_h;
    logic        ssyn_out_h;

    int checks   = 0;
    int failures = 0;

`ifdef PC11F_OVFERR_EN
    localparam logic [15:0] OVF_XCSR = 16'h8000;
`else
    localparam logic [15:0] OVF_XCSR = 16'h0000;
`endif

    pc11_fifo dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
        .armwdata(armwdata), .armrdata(armrdata),
        .intreq(intreq), .intvec(intvec),
        .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
        .init_in_h(init_in_h), .msyn_in_h(msyn_in_h),
        .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
    );

    initial CLOCK = 1'b0;
    always #10 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic peek(input logic [1:0] r, output logic [31:0] v);
        armraddr = r;
        #1;
        v = armrdata;
    endtask

    task automatic arm_wr(input logic [1:0] r, input logic [31:0] d);
        armwrite = 1'b1;
        armwaddr = r;
        armwdata = d;
        tick();
        armwrite = 1'b0;
        $display("ARM  wr reg%0d data=%h", r, d);
    endtask

    // Full MSYN/SSYN cycle; lat is clocks until SSYN, 8 means no response.
    task automatic ub_xfer(input logic [17:0] a, input logic wr, input logic bytem,
                           input logic [15:0] d, output logic [15:0] rd, output int lat);
        a_in_h    = a;
        c_in_h    = {wr, bytem};
        d_in_h    = d;
        msyn_in_h = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ssyn_out_h && lat < 8);
        rd = d_out_h;
        msyn_in_h = 1'b0;
        tick();
        $display("UB   %s a=%o d=%h rd=%h lat=%0d", wr ? "wr" : "rd", a, d, rd, lat);
    endtask

    logic [31:0] v;
    logic [15:0] rd;
    int          lat;

    task automatic test_reset();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        peek(2, v); checks++;
        if (v !== 32'h00000080) begin failures++; $display("FAIL reset_reg2 got=%h exp=%h", v, 32'h00000080); end
        peek(3, v); checks++;
        if (v !== 32'h00E3FF68) begin failures++; $display("FAIL reset_reg3 got=%h exp=%h", v, 32'h00E3FF68); end
        peek(0, v); checks++;
        if (v !== 32'h50431002) begin failures++; $display("FAIL reset_reg0 got=%h exp=%h", v, 32'h50431002); end
        peek(1, v); checks++;
        if (v !== 32'h00000000) begin failures++; $display("FAIL reset_reg1 got=%h exp=%h", v, 32'h00000000); end
        checks++;
        if (ssyn_out_h !== 1'b0 || d_out_h !== 16'h0 || intreq !== 1'b0) begin
            failures++; $display("FAIL reset_outs got=%b/%h/%b exp=0/0000/0", ssyn_out_h, d_out_h, intreq);
        end
        ub_xfer(18'o777550, 1'b0, 1'b0, 16'h0, rd, lat); checks++;
        if (lat !== 8) begin failures++; $display("FAIL disabled_no_ssyn got=%0d exp=%0d", lat, 8); end
    endtask

    task automatic test_enable();
        arm_wr(3, 32'h80000000);
        peek(3, v); checks++;
        if (v !== 32'h80E3FF68) begin failures++; $display("FAIL enable_reg3 got=%h exp=%h", v, 32'h80E3FF68); end
    endtask

    task automatic test_reader();
        arm_wr(1, 32'h01410000);
        arm_wr(1, 32'h01420000);
        peek(1, v); checks++;
        if (v !== 32'h00020000) begin failures++; $display("FAIL rdr_pushed got=%h exp=%h", v, 32'h00020000); end
        a_in_h = 18'o777550; c_in_h = 2'b10; d_in_h = 16'o000101; msyn_in_h = 1'b1;
        tick();
        peek(1, v); checks++;
        if (v !== 32'h00020840 || ssyn_out_h !== 1'b1) begin
            failures++; $display("FAIL rdr_go_busy got=%h ssyn=%b exp=%h ssyn=1", v, ssyn_out_h, 32'h00020840);
        end
        msyn_in_h = 1'b0;
        tick();
        peek(1, v); checks++;
        if (v !== 32'h410100C0) begin failures++; $display("FAIL rdr_done got=%h exp=%h", v, 32'h410100C0); end
        checks++;
        if (intreq !== 1'b1 || intvec !== 8'h38) begin
            failures++; $display("FAIL rdr_irq got=%b/%h exp=1/38", intreq, intvec);
        end
        ub_xfer(18'o777550, 1'b0, 1'b0, 16'h0, rd, lat); checks++;
        if (rd !== 16'h00C0 || lat !== 1) begin failures++; $display("FAIL rdr_rcsr_read got=%h/%0d exp=00c0/1", rd, lat); end
        ub_xfer(18'o777552, 1'b0, 1'b0, 16'h0, rd, lat); checks++;
        if (rd !== 16'h0041) begin failures++; $display("FAIL rdr_rbuf_read got=%h exp=%h", rd, 16'h0041); end
        peek(1, v); checks++;
        if (v !== 32'h41010040 || intreq !== 1'b0) begin
            failures++; $display("FAIL rdr_done_clr got=%h irq=%b exp=%h irq=0", v, intreq, 32'h41010040);
        end
    endtask

    task automatic test_reader_wait();
        arm_wr(1, 32'h02000000);
        peek(1, v); checks++;
        if (v !== 32'h41000040) begin failures++; $display("FAIL rdr_flush got=%h exp=%h", v, 32'h41000040); end
        ub_xfer(18'o777550, 1'b1, 1'b0, 16'o000101, rd, lat);
        for (int i = 0; i < 10; i++) tick();
        peek(1, v); checks++;
        if (v !== 32'h00000840) begin failures++; $display("FAIL rdr_busy_hold got=%h exp=%h", v, 32'h00000840); end
        arm_wr(1, 32'h012D0000);
        peek(1, v); checks++;
        if (v !== 32'h00010840) begin failures++; $display("FAIL rdr_late_push got=%h exp=%h", v, 32'h00010840); end
        tick();
        peek(1, v); checks++;
        if (v !== 32'h2D0000C0) begin failures++; $display("FAIL rdr_late_done got=%h exp=%h", v, 32'h2D0000C0); end
        ub_xfer(18'o777552, 1'b0, 1'b0, 16'h0, rd, lat); checks++;
        if (rd !== 16'h002D) begin failures++; $display("FAIL rdr_late_rbuf got=%h exp=%h", rd, 16'h002D); end
    endtask

    task automatic test_punch();
        for (int i = 0; i < 16; i++) begin
            ub_xfer(18'o777556, 1'b1, 1'b0, 16'(16'h0010 + i), rd, lat); checks++;
            if (lat !== 1) begin failures++; $display("FAIL pun_write%0d_lat got=%0d exp=1", i, lat); end
        end
        peek(2, v); checks++;
        if (v !== 32'h10100000) begin failures++; $display("FAIL pun_full got=%h exp=%h", v, 32'h10100000); end
        ub_xfer(18'o777556, 1'b1, 1'b0, 16'h00AA, rd, lat); checks++;
        if (lat !== 1) begin failures++; $display("FAIL pun_ovf_ssyn got=%0d exp=1", lat); end
        peek(2, v); checks++;
        if (v !== {16'h1010, OVF_XCSR}) begin failures++; $display("FAIL pun_ovf_reg2 got=%h exp=%h", v, {16'h1010, OVF_XCSR}); end
        ub_xfer(18'o777554, 1'b0, 1'b0, 16'h0, rd, lat); checks++;
        if (rd !== OVF_XCSR) begin failures++; $display("FAIL pun_xcsr_read got=%h exp=%h", rd, OVF_XCSR); end
        ub_xfer(18'o777556, 1'b0, 1'b0, 16'h0, rd, lat); checks++;
        if (rd !== 16'h001F) begin failures++; $display("FAIL pun_xbuf_read got=%h exp=%h", rd, 16'h001F); end
        arm_wr(2, 32'h01000000);
        peek(2, v); checks++;
        if (v !== 32'h110F0080) begin failures++; $display("FAIL pun_pop got=%h exp=%h", v, 32'h110F0080); end
        ub_xfer(18'o777554, 1'b1, 1'b0, 16'o000100, rd, lat); checks++;
        if (intreq !== 1'b1 || intvec !== 8'h3C) begin
            failures++; $display("FAIL pun_irq got=%b/%h exp=1/3c", intreq, intvec);
        end
        arm_wr(2, 32'h02000000);
        peek(2, v); checks++;
        if (v !== 32'h000000C0) begin failures++; $display("FAIL pun_flush got=%h exp=%h", v, 32'h000000C0); end
        ub_xfer(18'o777554, 1'b1, 1'b0, 16'h0000, rd, lat);
    endtask

    task automatic test_back_to_back();
        armwrite = 1'b1; armwaddr = 2'd1; armwdata = 32'h01330000;
        a_in_h = 18'o777550; c_in_h = 2'b10; d_in_h = 16'o000101; msyn_in_h = 1'b1;
        tick();
        armwrite = 1'b0;
        peek(1, v); checks++;
        if (v !== 32'h2D010040 || ssyn_out_h !== 1'b0) begin
            failures++; $display("FAIL b2b_arm_first got=%h ssyn=%b exp=%h ssyn=0", v, ssyn_out_h, 32'h2D010040);
        end
        tick();
        peek(1, v); checks++;
        if (v !== 32'h00010840 || ssyn_out_h !== 1'b1) begin
            failures++; $display("FAIL b2b_ub_second got=%h ssyn=%b exp=%h ssyn=1", v, ssyn_out_h, 32'h00010840);
        end
        msyn_in_h = 1'b0;
        tick();
        peek(1, v); checks++;
        if (v !== 32'h330000C0 || ssyn_out_h !== 1'b0) begin
            failures++; $display("FAIL b2b_done got=%h ssyn=%b exp=%h ssyn=0", v, ssyn_out_h, 32'h330000C0);
        end
        ub_xfer(18'o777552, 1'b0, 1'b0, 16'h0, rd, lat); checks++;
        if (rd !== 16'h0033) begin failures++; $display("FAIL b2b_rbuf got=%h exp=%h", rd, 16'h0033); end
    endtask

    task automatic test_byte_odd();
        ub_xfer(18'o777551, 1'b1, 1'b1, 16'o000001, rd, lat);
        peek(1, v); checks++;
        if (v !== 32'h33000040 || lat !== 1) begin
            failures++; $display("FAIL byte_odd_ignored got=%h lat=%0d exp=%h lat=1", v, lat, 32'h33000040);
        end
        ub_xfer(18'o777550, 1'b1, 1'b1, 16'h0000, rd, lat);
        peek(1, v); checks++;
        if (v !== 32'h33000000) begin failures++; $display("FAIL byte_even got=%h exp=%h", v, 32'h33000000); end
    endtask

    task automatic test_init();
        ub_xfer(18'o777554, 1'b1, 1'b0, 16'o000100, rd, lat);
        arm_wr(2, 32'h00008000);
        peek(2, v); checks++;
        if (v !== 32'h000080C0) begin failures++; $display("FAIL init_pre_xcsr got=%h exp=%h", v, 32'h000080C0); end
        ub_xfer(18'o777550, 1'b1, 1'b0, 16'o000101, rd, lat);
        peek(1, v); checks++;
        if (v !== 32'h00000840) begin failures++; $display("FAIL init_pre_wait got=%h exp=%h", v, 32'h00000840); end
        init_in_h = 1'b1;
        arm_wr(1, 32'h01610000);
        arm_wr(1, 32'h01620000);
        arm_wr(1, 32'h01630000);
        init_in_h = 1'b0;
        tick();
        peek(1, v); checks++;
        if (v !== 32'h00030000) begin failures++; $display("FAIL init_reader got=%h exp=%h", v, 32'h00030000); end
        peek(2, v); checks++;
        if (v !== 32'h00000080) begin failures++; $display("FAIL init_xcsr got=%h exp=%h", v, 32'h00000080); end
        peek(3, v); checks++;
        if (v !== 32'h80E3FF68) begin failures++; $display("FAIL init_enable got=%h exp=%h", v, 32'h80E3FF68); end
        checks++;
        if (intreq !== 1'b0 || ssyn_out_h !== 1'b0) begin
            failures++; $display("FAIL init_outs got=%b/%b exp=0/0", intreq, ssyn_out_h);
        end
    endtask

    initial begin
        RESET = 1'b0; armwrite = 1'b0; armraddr = 2'd0; armwaddr = 2'd0; armwdata = '0;
        a_in_h = '0; c_in_h = '0; d_in_h = '0; init_in_h = 1'b0; msyn_in_h = 1'b0;
        tick();
        test_reset();
        test_enable();
        test_reader();
        test_reader_wait();
        test_punch();
        test_back_to_back();
        test_byte_odd();
        test_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc11_fifo.md
Name: pc11_fifo

Overview:
- Next-generation PC11 paper tape reader/punch Unibus slave.
- Adds parametrised byte FIFOs between the ARM-side tape emulator and the PDP-side registers, so the ARM can stream tape data ahead of and behind the PDP.
- Sits on the Unibus slave bus alongside the other emulated devices; the ARM accesses it through the 4-register armraddr/armwaddr window.

Parameters:
ADDR, 18'o777550, Unibus base address of RCSR; RBUF, XCSR and XBUF follow at +2, +4, +6.
INTVEC, 8'o070, reader vector; punch vector is INTVEC+4.
RDEPTHL2, 4, log2 of reader FIFO depth (1..7).
PDEPTHL2, 4, log2 of punch FIFO depth (1..7).

Ports:
CLOCK  in  1  system clock, all logic on rising edge.
RESET  in  1  synchronous, active-low reset.
armwrite  in  1  ARM register write strobe, one cycle.
armraddr  in  2  ARM read register select.
armwaddr  in  2  ARM write register select.
armwdata  in  32  ARM write data.
armrdata  out  32  ARM read data, combinational.
intreq  out  1  interrupt request.
intvec  out  8  interrupt vector.
a_in_h  in  18  Unibus address.
c_in_h  in  2  Unibus control: [1] write, [0] byte.
d_in_h  in  16  Unibus write data.
init_in_h  in  1  Unibus INIT.
msyn_in_h  in  1  Unibus MSYN.
d_out_h  out  16  Unibus read data, registered.
ssyn_out_h  out  1  Unibus SSYN, registered.

Behaviour:
- armrdata map:
  - 0 = 32'h50431002.
  - 1 = {rbuf[7:0], rcnt[7:0], rcsr}.
  - 2 = {pfifo head[7:0], pcnt[7:0], xcsr}.
  - 3 = {enable, 5'b0, INTVEC, ADDR}.
  - rcnt and pcnt are FIFO occupancies, zero-extended.
- RESET low:
  - enable=0; both FIFOs emptied; rcsr=0, rbuf=0, xcsr=0, xbuf=0.
  - xcsr[7] then tracks the punch FIFO (1 when not full).
  - d_out_h=0, ssyn_out_h=0; reader FSM to IDLE.
- init_in_h high with RESET high:
  - rcsr=0, xcsr[15]=0, xcsr[6]=0, d_out_h=0, ssyn_out_h=0; reader FSM to IDLE.
  - FIFOs and enable preserved.
- ARM write to reg1:
  - [25] flushes the reader FIFO.
  - else [24] pushes [23:16] if the FIFO is not full; push when full is dropped.
  - [15] loads rcsr[15] (ERROR).
- ARM write to reg2:
  - [25] flushes the punch FIFO.
  - else [24] pops the head if the FIFO is not empty.
  - [15] loads xcsr[15].
- ARM write to reg3: [31] loads enable.
- Priority: an ARM write and a Unibus cycle in the same clock -> ARM write wins. The Unibus cycle is serviced on the next clock (SSYN delayed one cycle). FIFO push and pop in the same cycle are both honoured, and the count is unchanged.
- Unibus handshake:
  - msyn low -> d_out_h=0, ssyn=0 next clock.
  - msyn high, enable, a_in_h[17:3]==ADDR[17:3], ssyn low -> ssyn=1 next clock, plus the register action below.
  - ssyn held until msyn drops.
  - Byte writes to the odd address are ignored, except the XBUF-write side effect.
- Reader FSM: IDLE, WAIT.
  - PDP writes RCSR with bit0=1 -> rcsr[7]=0, rcsr[11]=1, rbuf=0, go to WAIT. rcsr[6] is always loaded from the write.
  - In WAIT with the reader FIFO not empty: rbuf = head, pop, rcsr[11]=0, rcsr[7]=1, go to IDLE. One byte per GO.
  - In WAIT with the FIFO empty: stay. ARM setting ERROR also returns to IDLE with rcsr[11]=0.
  - GO while in WAIT: no effect.
  - PDP read of RBUF clears rcsr[7].
- Punch:
  - xcsr[7] (READY) = punch FIFO not full, live.
  - PDP write of XBUF pushes d_in_h[7:0] and updates xbuf; ignored if full.
  - XCSR write loads xcsr[6].
- PDP reads:
  - RCSR -> rcsr & 16'o104300.
  - RBUF -> rbuf.
  - XCSR -> xcsr & 16'o100300.
  - XBUF -> xbuf.
- Interrupts:
  - rirq = (rcsr[15] | rcsr[7]) & rcsr[6].
  - xirq = (xcsr[15] | xcsr[7]) & xcsr[6].
  - intreq = rirq | xirq.
  - intvec = {INTVEC[7:3], ~rirq, 2'b0}; the reader has priority.
- FIFO pointers wrap modulo depth. The count is RDEPTHL2+1 / PDEPTHL2+1 bits wide, so full == (count == depth).

Optional Feature:
- Macro: PC11F_OVFERR_EN.
- Defined: a PDP XBUF write while the punch FIFO is full sets xcsr[15]. A reader push from the ARM while full sets rcsr[15]. SSYN is still returned.
- Undefined: the overflowing write is silently discarded; the error bits change only via ARM writes.

Test Plan:
- RESET low 1 cycle, then read ARM reg2 -> pcnt=0, xcsr=16'o000200. Reg3 -> enable=0.
- Enable; ARM pushes 8'o101, 8'o102; PDP writes RCSR=16'o000101 -> rcsr[11] set, then within 2 clocks RBUF=8'o101, rcsr[7]=1. intreq=1, intvec=8'o070. PDP read RBUF -> 8'o101, rcsr[7] cleared.
- GO with the reader FIFO empty -> busy holds 10 cycles. ARM push 8'o055 -> next clock rbuf=8'o055, done=1.
- PDP writes XBUF 16 times with PDEPTHL2=4 -> xcsr[7]=0 after the 16th. 17th write is dropped and xcsr[15]=1 only with PC11F_OVFERR_EN. ARM pop -> xcsr[7]=1.
- ARM write and MSYN to RCSR in the same clock -> SSYN rises one clock later than normal; both actions take effect.
- init_in_h pulse mid-WAIT with 3 bytes queued -> rcsr=0, FSM IDLE, rcnt still 3.
